// File: rtl/cpu_trace_pkg.sv
// Shared types and field layout for the CPU execution-trace recorder.
// Build option: TRACE_TSTAMP_EN prepends a free-running timestamp to every entry.
package cpu_trace_pkg;

`ifdef TRACE_TSTAMP_EN
    localparam bit TSTAMP_EN = 1'b1;
`else
    localparam bit TSTAMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        POST  = 2'b10,
        DONE  = 2'b11
    } trace_state_t;

    localparam int DEF_INSTR_W = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_ALU_W   = 3;
    localparam int DEF_STATE_W = 2;
    localparam int DEF_PORT_W  = 8;
    localparam int DEF_TS_W    = 16;

    // Entry layout, LSB first: oport, state, alu_mode, oaddr, iaddr, instr, [ts]
    localparam int OPORT_LSB = 0;
    localparam int STATE_LSB = OPORT_LSB + DEF_PORT_W;
    localparam int ALU_LSB   = STATE_LSB + DEF_STATE_W;
    localparam int OADDR_LSB = ALU_LSB + DEF_ALU_W;
    localparam int IADDR_LSB = OADDR_LSB + DEF_ADDR_W;
    localparam int INSTR_LSB = IADDR_LSB + DEF_ADDR_W;
    localparam int TS_LSB    = INSTR_LSB + DEF_INSTR_W;

    function automatic int entry_w(input int iw, input int aw, input int alw,
                                   input int sw, input int pw, input int tw);
        return (TSTAMP_EN ? tw : 0) + iw + 2 * aw + alw + sw + pw;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered synchronous read.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 37
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // The read register is reset and only moves on a read, so it doubles as rd_data.
    always_ff @(posedge clk) begin
        if (reset)     rdata_o <= '0;
        else if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/cpu_trace_buffer.sv
// Triggered circular execution-trace capture with oldest-first readout.
// Build option: TRACE_TSTAMP_EN adds a TS_W cycle counter sampled into each entry's MSBs.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int INSTR_W   = 8,
    parameter int ADDR_W    = 8,
    parameter int ALU_W     = 3,
    parameter int STATE_W   = 2,
    parameter int PORT_W    = 8,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int TS_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       smp_valid,
    input  logic [INSTR_W-1:0]         smp_instr,
    input  logic [ADDR_W-1:0]          smp_iaddr,
    input  logic [ADDR_W-1:0]          smp_oaddr,
    input  logic [ALU_W-1:0]           smp_alu_mode,
    input  logic [STATE_W-1:0]         smp_state,
    input  logic [PORT_W-1:0]          smp_oport,
    input  logic                       arm,
    input  logic [ADDR_W-1:0]          trig_addr,
    input  logic                       force_trig,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [entry_w(INSTR_W, ADDR_W, ALU_W, STATE_W, PORT_W, TS_W)-1:0] rd_data,
    output logic                       armed,
    output logic                       done,
    output logic                       wrapped,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = entry_w(INSTR_W, ADDR_W, ALU_W, STATE_W, PORT_W, TS_W);

    if (POST_TRIG < 0 || POST_TRIG >= DEPTH) begin : g_post_chk
        $error("POST_TRIG must satisfy 0 <= POST_TRIG < DEPTH");
    end
    if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_depth_chk
        $error("DEPTH must be a power of two and at least 4");
    end

    trace_state_t        state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_cnt_q, post_cnt_d;
    logic [AW:0]         count_q, count_d, left_q, left_d;
    logic                wrapped_q, wrapped_d, rd_valid_q, rd_valid_d;
    logic                we, re, trig_hit;
    logic [ENTRY_W-1:0]  wdata;

`ifdef TRACE_TSTAMP_EN
    logic [TS_W-1:0] ts_q;
    always_ff @(posedge clk) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + 1'b1;
    end
    assign wdata = {ts_q, smp_instr, smp_iaddr, smp_oaddr, smp_alu_mode, smp_state, smp_oport};
`else
    assign wdata = {smp_instr, smp_iaddr, smp_oaddr, smp_alu_mode, smp_state, smp_oport};
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        post_cnt_d = post_cnt_q;
        count_d    = count_q;
        left_d     = left_q;
        wrapped_d  = wrapped_q;
        rd_valid_d = 1'b0;
        we         = 1'b0;
        re         = 1'b0;
        trig_hit   = smp_valid && ((smp_iaddr == trig_addr) || force_trig);
        if (arm) begin
            state_d   = ARMED;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            left_d    = '0;
            wrapped_d = 1'b0;
        end else begin
            case (state_q)
                ARMED, POST: if (smp_valid) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (count_q != (AW+1)'(DEPTH)) count_d = count_q + 1'b1;
                    if (wr_ptr_q == AW'(DEPTH - 1)) wrapped_d = 1'b1;
                    if (state_q == ARMED) begin
                        if (trig_hit) begin
                            post_cnt_d = AW'(POST_TRIG);
                            state_d    = (POST_TRIG == 0) ? DONE : POST;
                        end
                    end else begin
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == AW'(1)) state_d = DONE;
                    end
                    // Readout starts at the oldest surviving entry.
                    if (state_d == DONE) begin
                        rd_ptr_d = wrapped_d ? wr_ptr_d : '0;
                        left_d   = count_d;
                    end
                end
                DONE: if (rd_en && left_q != '0) begin
                    re         = 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    left_d     = left_q - 1'b1;
                    rd_valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            post_cnt_q <= '0;
            count_q    <= '0;
            left_q     <= '0;
            wrapped_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            post_cnt_q <= post_cnt_d;
            count_q    <= count_d;
            left_q     <= left_d;
            wrapped_q  <= wrapped_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    trace_ram #(.DEPTH(DEPTH), .W(ENTRY_W)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .re_i    (re),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign rd_valid = rd_valid_q;
    assign armed    = (state_q == ARMED) || (state_q == POST);
    assign done     = (state_q == DONE);
    assign wrapped  = wrapped_q;
    assign count    = count_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_cpu_trace_buffer;
    import cpu_trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int PT    = 4;
    localparam int TSW   = 16;
    localparam int BW    = 8 + 2 * 8 + 3 + 2 + 8;
    localparam int EW    = entry_w(8, 8, 3, 2, 8, TSW);

    logic          clk = 1'b0;
    logic          reset, smp_valid, arm, force_trig, rd_en;
    logic [7:0]    smp_instr, smp_iaddr, smp_oaddr, smp_oport, trig_addr;
    logic [2:0]    smp_alu_mode;
    logic [1:0]    smp_state;
    logic          rd_valid, armed, done, wrapped;
    logic [EW-1:0] rd_data;
    logic [4:0]    count;
    logic          rd_valid_z, armed_z, done_z, wrapped_z;
    logic [EW-1:0] rd_data_z;
    logic [4:0]    count_z;

    always #5 clk = ~clk;

    cpu_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(PT), .TS_W(TSW)) dut (
        .clk(clk), .reset(reset), .smp_valid(smp_valid), .smp_instr(smp_instr),
        .smp_iaddr(smp_iaddr), .smp_oaddr(smp_oaddr), .smp_alu_mode(smp_alu_mode),
        .smp_state(smp_state), .smp_oport(smp_oport), .arm(arm), .trig_addr(trig_addr),
        .force_trig(force_trig), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .armed(armed), .done(done), .wrapped(wrapped), .count(count));

    cpu_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(0), .TS_W(TSW)) dut0 (
        .clk(clk), .reset(reset), .smp_valid(smp_valid), .smp_instr(smp_instr),
        .smp_iaddr(smp_iaddr), .smp_oaddr(smp_oaddr), .smp_alu_mode(smp_alu_mode),
        .smp_state(smp_state), .smp_oport(smp_oport), .arm(arm), .trig_addr(trig_addr),
        .force_trig(force_trig), .rd_en(rd_en), .rd_valid(rd_valid_z), .rd_data(rd_data_z),
        .armed(armed_z), .done(done_z), .wrapped(wrapped_z), .count(count_z));

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: 0 idle, 1 waiting for trigger, 2 post-trigger, 3 frozen
    int          m_st = 0, m_total = 0, m_left = 0;
    logic [BW-1:0] m_hist[$], m_rdq[$];
    logic          m_rv = 1'b0;
    logic [BW-1:0] m_rd = '0;

    task automatic model_update();
        logic [BW-1:0] e;
        e    = {smp_instr, smp_iaddr, smp_oaddr, smp_alu_mode, smp_state, smp_oport};
        m_rv = 1'b0;
        if (reset) begin
            m_st = 0; m_total = 0; m_hist.delete(); m_rdq.delete(); m_rd = '0;
        end else if (arm) begin
            m_st = 1; m_total = 0; m_hist.delete(); m_rdq.delete();
        end else if ((m_st == 1 || m_st == 2) && smp_valid) begin
            m_hist.push_back(e);
            if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
            m_total++;
            if (m_st == 1) begin
                if (smp_iaddr == trig_addr || force_trig) begin
                    m_left = PT;
                    m_st   = (PT == 0) ? 3 : 2;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_st = 3;
            end
            if (m_st == 3) m_rdq = m_hist;
        end else if (m_st == 3 && rd_en && m_rdq.size() > 0) begin
            m_rd = m_rdq.pop_front();
            m_rv = 1'b1;
        end
    endtask

    task automatic check_outputs();
        int exp_cnt;
        exp_cnt = (m_total > DEPTH) ? DEPTH : m_total;
        chk("armed",    64'(armed),    64'(m_st == 1 || m_st == 2));
        chk("done",     64'(done),     64'(m_st == 3));
        chk("count",    64'(count),    64'(exp_cnt));
        chk("wrapped",  64'(wrapped),  64'(m_total >= DEPTH));
        chk("rd_valid", 64'(rd_valid), 64'(m_rv));
        chk("rd_data",  64'(rd_data[BW-1:0]), 64'(m_rd));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [7:0] ia, input logic frc,
                         input logic a, input logic re, input logic rst);
        smp_valid    = v;
        smp_iaddr    = ia;
        force_trig   = frc;
        arm          = a;
        rd_en        = re;
        reset        = rst;
        smp_instr    = 8'($urandom);
        smp_oaddr    = 8'($urandom);
        smp_alu_mode = 3'($urandom);
        smp_state    = 2'($urandom);
        smp_oport    = 8'($urandom);
        step();
    endtask

    initial begin
        logic rs, a;
`ifdef TRACE_TSTAMP_EN
        logic [TSW-1:0] ts[3];
`endif
        trig_addr = 8'd0;
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("rst_armed", 64'(armed), 64'(0));
        chk("rst_done",  64'(done),  64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_rdata", 64'(rd_data), 64'(0));

        // Samples and reads while idle have no effect
        for (int i = 0; i < 5; i++) drive(1, 8'(i), 0, 0, 1, 0);
        chk("idle_count", 64'(count),    64'(0));
        chk("idle_rv",    64'(rd_valid), 64'(0));

        // Wrapping capture: trigger at 20, four post samples
        trig_addr = 8'd20;
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 30; i++) begin
            drive(1, 8'(i), 0, 0, 0, 0);
            if (i == 23) chk("t2_not_done", 64'(done), 64'(0));
            if (i == 24) chk("t2_done",     64'(done), 64'(1));
        end
        chk("t2_wrapped", 64'(wrapped), 64'(1));
        chk("t2_count",   64'(count),   64'(16));
        for (int k = 0; k < 16; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            chk("t2_rd_iaddr", 64'(rd_data[IADDR_LSB +: 8]), 64'(9 + k));
        end

        // Short capture, no wrap, then one read too many
        trig_addr = 8'd3;
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'(i), 0, 0, 0, 0);
            if (i == 6) chk("t3_not_done", 64'(done), 64'(0));
            if (i == 7) chk("t3_done",     64'(done), 64'(1));
        end
        chk("t3_wrapped", 64'(wrapped), 64'(0));
        chk("t3_count",   64'(count),   64'(8));
        for (int k = 0; k < 9; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            if (k < 8) chk("t3_rd_iaddr", 64'(rd_data[IADDR_LSB +: 8]), 64'(k));
            else       chk("t3_extra_rv", 64'(rd_valid), 64'(0));
        end

        // Forced trigger on the zero-post-trigger instance
        trig_addr = 8'hFF;
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        chk("t4_force_novalid", 64'(done_z), 64'(0));
        drive(1, 8'd1, 0, 0, 0, 0);
        drive(1, 8'd2, 0, 0, 0, 0);
        drive(1, 8'h5A, 1, 0, 0, 0);
        chk("t4_done",  64'(done_z),  64'(1));
        chk("t4_count", 64'(count_z), 64'(3));
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            chk("t4_rv", 64'(rd_valid_z), 64'(1));
        end
        chk("t4_last_iaddr", 64'(rd_data_z[IADDR_LSB +: 8]), 64'(8'h5A));

        // Reset in the middle of post-trigger capture, then re-arm
        trig_addr = 8'd3;
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 8'(i), 0, 0, 0, 0);
        chk("t5_in_post", 64'(armed), 64'(1));
        drive(0, 0, 0, 0, 0, 1);
        chk("t5_armed", 64'(armed), 64'(0));
        chk("t5_done",  64'(done),  64'(0));
        chk("t5_count", 64'(count), 64'(0));
        trig_addr = 8'd12;
        drive(0, 0, 0, 1, 0, 0);
        for (int i = 10; i < 17; i++) drive(1, 8'(i), 0, 0, 0, 0);
        chk("t5_redone", 64'(done),  64'(1));
        chk("t5_recnt",  64'(count), 64'(7));
        drive(0, 0, 0, 0, 1, 0);
        chk("t5_first", 64'(rd_data[IADDR_LSB +: 8]), 64'(10));

`ifdef TRACE_TSTAMP_EN
        // Samples spaced 3 then 7 cycles apart
        trig_addr = 8'hFF;
        drive(0, 0, 0, 1, 0, 0);
        drive(1, 8'd1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 0, 0);
        drive(1, 8'd2, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 0);
        drive(1, 8'd3, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            ts[k] = rd_data_z[EW-1 -: TSW];
        end
        chk("ts_gap3", 64'(TSW'(ts[1] - ts[0])), 64'(3));
        chk("ts_gap7", 64'(TSW'(ts[2] - ts[1])), 64'(7));
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 399) == 0);
            a  = (i == 0) || ($urandom_range(0, 119) == 0);
            if (a) trig_addr = 8'($urandom_range(0, 31));
            drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 31)),
                  $urandom_range(0, 49) == 0, a, $urandom_range(0, 1) == 1, rs);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
